// File: rtl/line_unpack_fifo.sv
// line_unpack_fifo
// Read-side unpacker for a wide memory read channel. One line at a time is
// captured. A contiguous range of WIDTH-bit elements from that line is then
// streamed, one per cycle, into a small show-ahead FIFO for the consumers.
// A separate combinational path pulls any single 64-bit word out of the
// incoming line. These word fetches do not go through the FIFO.
// Both element and word indexing are MSB-first: index 0 is the top slice.

module line_unpack_fifo #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  // unpacker load side
  input  logic                               load,
  input  logic [FULL_WIDTH-1:0]              line_data,
  input  logic [7:0]                         base,
  input  logic [7:0]                         bounds,
  output logic                               busy,
  // FIFO consumer side
  input  logic                               pop,
  output logic [WIDTH-1:0]                   q,
  output logic                               empty,
  output logic                               full,
  output logic [LOG_DEPTH:0]                 count,
  // 64-bit word extraction
  input  logic                               parse_valid,
  input  logic [$clog2(FULL_WIDTH/64)-1:0]   parse_idx,
  output logic [63:0]                        parse_word
);

  // Elements per line and 64-bit words per line.
  localparam int N     = FULL_WIDTH / WIDTH;
  localparam int NW    = FULL_WIDTH / 64;
  localparam int DEPTH = 1 << LOG_DEPTH;

  // The index registers must hold every value of the 8-bit base/bounds
  // inputs and the value N. They must also leave room for the comparison
  // against end. At least 9 bits keeps the zero-extension of the 8-bit
  // ports well defined.
  localparam int IW  = ($clog2(N + 1) > 9) ? $clog2(N + 1) : 9;
  // Width of the element selector. While busy, idx is always below N.
  localparam int ESW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0]       N_IDX     = IW'(N);
  localparam logic [LOG_DEPTH:0]  DEPTH_CNT = {1'b1, {LOG_DEPTH{1'b0}}};

  // ---------------------------------------------------------------------
  // Unpacker state
  // ---------------------------------------------------------------------
  logic [FULL_WIDTH-1:0] line_reg;
  logic [IW-1:0]         idx_reg;
  logic [IW-1:0]         end_reg;
  logic                  busy_reg;

  logic [IW-1:0]         base_ext;
  logic [IW-1:0]         bounds_ext;
  logic [IW-1:0]         end_clamped;
  logic [IW-1:0]         idx_next;
  logic [ESW-1:0]        elem_sel;
  logic [WIDTH-1:0]      push_data;

  // Held line split into MSB-first elements.
  logic [WIDTH-1:0]      elem [N];
  // Incoming line split into MSB-first 64-bit words for the parser.
  logic [63:0]           word [NW];

  // ---------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr_reg;
  logic [LOG_DEPTH-1:0]  rd_ptr_reg;
  logic [LOG_DEPTH:0]    count_reg;
  logic [LOG_DEPTH:0]    count_next;
  logic                  empty_reg;
  logic                  full_reg;

  logic                  push;
  logic                  pop_ok;

  // ---------------------------------------------------------------------
  // Slicing of the held line and of the parser input
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign elem[gi] = line_reg[FULL_WIDTH-1-WIDTH*gi -: WIDTH];
    end
    for (gi = 0; gi < NW; gi++) begin : g_word
      assign word[gi] = line_data[FULL_WIDTH-1-64*gi -: 64];
    end
  endgenerate

  // Load-time range arithmetic: the end index is clamped to the element count.
  assign base_ext    = IW'(base);
  assign bounds_ext  = IW'(bounds);
  assign end_clamped = (bounds_ext > N_IDX) ? N_IDX : bounds_ext;
  assign idx_next    = idx_reg + IW'(1);
  assign elem_sel    = idx_reg[ESW-1:0];
  assign push_data   = elem[elem_sel];

  // The unpacker pushes only when the FIFO has room. Because of this, a
  // push and a pop can never collide on a full FIFO. A pop of an empty
  // FIFO is dropped, even when a push happens in the same cycle.
  assign push   = busy_reg & ~full_reg;
  assign pop_ok = pop & ~empty_reg;

  // Unpacker: latch a line when idle, then walk idx up to end, one element per non-full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_reg <= '0;
      idx_reg  <= '0;
      end_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (busy_reg) begin
      // A load while busy is ignored. Upstream gates its reads on busy.
      if (!full_reg) begin
        idx_reg <= idx_next;
        if (idx_next >= end_reg) begin
          busy_reg <= 1'b0;
        end
      end
    end else if (load) begin
      line_reg <= line_data;
      idx_reg  <= base_ext;
      end_reg  <= end_clamped;
      busy_reg <= (base_ext < end_clamped);
    end
  end

  // FIFO storage write. The contents need no reset because q is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Next occupancy: a push and a pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == DEPTH_CNT);
    end
  end

  // Show-ahead head of the FIFO. It reads as zero whenever the FIFO is empty.
  assign q     = empty_reg ? '0 : mem[rd_ptr_reg];
  assign empty = empty_reg;
  assign full  = full_reg;
  assign count = count_reg;
  assign busy  = busy_reg;

  // Zero-latency word extraction from the incoming line.
  assign parse_word = parse_valid ? word[parse_idx] : 64'd0;

endmodule

// File: tb/tb_line_unpack_fifo.sv
// Testbench for line_unpack_fifo.
// It uses two instances: a 64-bit element unpacker (dut_a) and a 128-bit
// element unpacker (dut_b). Expected elements go into per-instance queues
// when a line is loaded. Each entry is popped and compared when the DUT
// presents it on q.

module tb_line_unpack_fifo;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- dut_a: WIDTH=64 ----------------
  logic         a_load;
  logic [511:0] a_line;
  logic [7:0]   a_base, a_bounds;
  logic         a_busy, a_pop, a_empty, a_full;
  logic [63:0]  a_q;
  logic [4:0]   a_count;
  logic         a_pv;
  logic [2:0]   a_pidx;
  logic [63:0]  a_pw;

  // ---------------- dut_b: WIDTH=128 ----------------
  logic         b_load;
  logic [511:0] b_line;
  logic [7:0]   b_base, b_bounds;
  logic         b_busy, b_pop, b_empty, b_full;
  logic [127:0] b_q;
  logic [4:0]   b_count;
  logic         b_pv;
  logic [2:0]   b_pidx;
  logic [63:0]  b_pw;

  logic [63:0]  exp_a[$];
  logic [127:0] exp_b[$];

  line_unpack_fifo #(.FULL_WIDTH(512), .WIDTH(64), .LOG_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .load(a_load), .line_data(a_line), .base(a_base), .bounds(a_bounds),
    .busy(a_busy), .pop(a_pop), .q(a_q), .empty(a_empty), .full(a_full),
    .count(a_count), .parse_valid(a_pv), .parse_idx(a_pidx), .parse_word(a_pw)
  );

  line_unpack_fifo #(.FULL_WIDTH(512), .WIDTH(128), .LOG_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .load(b_load), .line_data(b_line), .base(b_base), .bounds(b_bounds),
    .busy(b_busy), .pop(b_pop), .q(b_q), .empty(b_empty), .full(b_full),
    .count(b_count), .parse_valid(b_pv), .parse_idx(b_pidx), .parse_word(b_pw)
  );

  // Line whose 64-bit word k (MSB-first) holds start+k.
  function automatic logic [511:0] mk_line(input logic [63:0] start);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[511-64*k -: 64] = start + 64'(k);
    return l;
  endfunction

  // Present a line on dut_a for one edge.
  task automatic load_a(input logic [511:0] line, input logic [7:0] b, input logic [7:0] e);
    a_line = line; a_base = b; a_bounds = e; a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if (a_empty !== 1'b1 || a_count !== 5'd0 || a_busy !== 1'b0 || a_full !== 1'b0 || a_q !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_a: empty=%0b count=%0d busy=%0b full=%0b q=%h, required 1 0 0 0 0",
               a_empty, a_count, a_busy, a_full, a_q);
    end
    tests_run++;
    if (b_empty !== 1'b1 || b_count !== 5'd0 || b_busy !== 1'b0 || b_q !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_b: empty=%0b count=%0d busy=%0b q=%h, required 1 0 0 0",
               b_empty, b_count, b_busy, b_q);
    end
    $display("[TB] reset state checked");
  endtask

  // Range loads with continuous popping: order, clamping, busy duration.
  task automatic test_ranges;
    int tb_base[6]   = '{0, 3, 3, 7, 0, 7};
    int tb_bounds[6] = '{8, 6, 12, 8, 1, 200};
    int tb_busy[6]   = '{8, 3, 5, 1, 1, 1};
    logic [63:0] ev;
    int busy_cycles, cyc, hi;
    for (int t = 0; t < 6; t++) begin
      hi = (tb_bounds[t] > 8) ? 8 : tb_bounds[t];
      for (int i = tb_base[t]; i < hi; i++) exp_a.push_back(64'(i + 1));
      a_pop = 1'b1;
      load_a(mk_line(64'd1), 8'(tb_base[t]), 8'(tb_bounds[t]));
      busy_cycles = 0; cyc = 0;
      while (exp_a.size() > 0 && cyc < 60) begin
        if (a_busy) busy_cycles++;
        if (!a_empty) begin
          ev = exp_a.pop_front();
          tests_run++;
          if (a_q !== ev) begin
            tests_failed++;
            $display("FAIL range_q: case %0d q=%0d, required %0d", t, a_q, ev);
          end
        end
        @(posedge clk); #1; cyc++;
      end
      tests_run++;
      if (exp_a.size() != 0) begin
        tests_failed++;
        $display("FAIL range_timeout: case %0d %0d elements never appeared", t, exp_a.size());
        exp_a.delete();
      end
      tests_run++;
      if (busy_cycles != tb_busy[t]) begin
        tests_failed++;
        $display("FAIL range_busy: case %0d busy cycles=%0d, required %0d", t, busy_cycles, tb_busy[t]);
      end
      tests_run++;
      if (a_empty !== 1'b1 || a_busy !== 1'b0 || a_count !== 5'd0) begin
        tests_failed++;
        $display("FAIL range_drained: case %0d empty=%0b busy=%0b count=%0d, required 1 0 0",
                 t, a_empty, a_busy, a_count);
      end
      a_pop = 1'b0;
      $display("[TB] range base=%0d bounds=%0d busy_cycles=%0d", tb_base[t], tb_bounds[t], busy_cycles);
    end
  endtask

  // base >= clamped end: nothing emitted, busy never rises.
  task automatic test_empty_range;
    int tb_base[4]   = '{5, 6, 8, 200};
    int tb_bounds[4] = '{5, 2, 12, 255};
    for (int t = 0; t < 4; t++) begin
      load_a(mk_line(64'd1), 8'(tb_base[t]), 8'(tb_bounds[t]));
      for (int c = 0; c < 4; c++) begin
        tests_run++;
        if (a_busy !== 1'b0 || a_empty !== 1'b1) begin
          tests_failed++;
          $display("FAIL empty_range: case %0d cycle %0d busy=%0b empty=%0b, required 0 1",
                   t, c, a_busy, a_empty);
        end
        @(posedge clk); #1;
      end
      $display("[TB] empty range base=%0d bounds=%0d", tb_base[t], tb_bounds[t]);
    end
  endtask

  // Three lines without popping: fill to 16, stall, ignored load, exact drain.
  task automatic test_back_to_back;
    logic [63:0] ev;
    int n;
    a_pop = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) exp_a.push_back(64'(8 * l + i + 1));
      load_a(mk_line(64'(8 * l + 1)), 8'd0, 8'd8);
      if (l < 2) begin
        n = 0;
        while (a_busy && n < 40) begin @(posedge clk); #1; n++; end
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if (a_full !== 1'b1 || a_count !== 5'd16 || a_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_full: full=%0b count=%0d busy=%0b, required 1 16 1", a_full, a_count, a_busy);
    end
    // Load while busy must be dropped.
    load_a(mk_line(64'd100), 8'd0, 8'd8);
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (a_count !== 5'd16 || a_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_stall: count=%0d busy=%0b, required 16 1", a_count, a_busy);
    end
    a_pop = 1'b1;
    n = 0;
    while (exp_a.size() > 0 && n < 100) begin
      if (!a_empty) begin
        ev = exp_a.pop_front();
        tests_run++;
        if (a_q !== ev) begin
          tests_failed++;
          $display("FAIL bp_order: q=%0d, required %0d", a_q, ev);
        end
      end
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (exp_a.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_timeout: %0d elements never appeared", exp_a.size());
      exp_a.delete();
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (a_empty !== 1'b1 || a_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_extra: cycle %0d empty=%0b busy=%0b q=%0d, required 1 0", c, a_empty, a_busy, a_q);
      end
      @(posedge clk); #1;
    end
    a_pop = 1'b0;
    $display("[TB] backpressure: 3 lines, 24 elements drained");
  endtask

  // 128-bit elements built from 64-bit pairs; bounds above N=4 clamps.
  task automatic test_wide;
    logic [63:0]  wa[4], wb[4];
    logic [127:0] ev;
    int bnd[2] = '{4, 8};
    int n;
    for (int t = 0; t < 2; t++) begin
      b_line = '0;
      for (int i = 0; i < 4; i++) begin
        wa[i] = {$urandom, $urandom};
        wb[i] = {$urandom, $urandom};
        b_line[511-128*i -: 64] = wa[i];
        b_line[447-128*i -: 64] = wb[i];
        exp_b.push_back({wa[i], wb[i]});
      end
      b_base = 8'd0; b_bounds = 8'(bnd[t]); b_load = 1'b1; b_pop = 1'b1;
      @(posedge clk); #1;
      b_load = 1'b0;
      n = 0;
      while (exp_b.size() > 0 && n < 40) begin
        if (!b_empty) begin
          ev = exp_b.pop_front();
          tests_run++;
          if (b_q !== ev) begin
            tests_failed++;
            $display("FAIL wide_q: case %0d q=%h, required %h", t, b_q, ev);
          end
        end
        @(posedge clk); #1; n++;
      end
      tests_run++;
      if (exp_b.size() != 0 || b_empty !== 1'b1 || b_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL wide_end: case %0d left=%0d empty=%0b busy=%0b, required 0 1 0",
                 t, exp_b.size(), b_empty, b_busy);
        exp_b.delete();
      end
      b_pop = 1'b0;
      $display("[TB] wide bounds=%0d checked", bnd[t]);
    end
  endtask

  task automatic test_parser;
    a_line = mk_line(64'd1);
    a_pv = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_pidx = 3'(k);
      #1;
      tests_run++;
      if (a_pw !== 64'(k + 1)) begin
        tests_failed++;
        $display("FAIL parse_word: idx %0d got %0d, required %0d", k, a_pw, k + 1);
      end
    end
    a_pv = 1'b0;
    #1;
    tests_run++;
    if (a_pw !== 64'd0) begin
      tests_failed++;
      $display("FAIL parse_invalid: got %h, required 0", a_pw);
    end
    $display("[TB] parser words 0..7 checked");
  endtask

  task automatic test_reset_midstream;
    a_pop = 1'b0;
    load_a(mk_line(64'd1), 8'd0, 8'd8);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests_run++;
    if (a_empty !== 1'b1 || a_count !== 5'd0 || a_busy !== 1'b0 || a_full !== 1'b0 || a_q !== 64'd0) begin
      tests_failed++;
      $display("FAIL midreset: empty=%0b count=%0d busy=%0b full=%0b q=%h, required 1 0 0 0 0",
               a_empty, a_count, a_busy, a_full, a_q);
    end
    #1 rst = 1'b0;
    exp_a.delete();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (a_empty !== 1'b1 || a_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_after: cycle %0d empty=%0b busy=%0b, required 1 0", c, a_empty, a_busy);
      end
    end
    $display("[TB] mid-stream reset checked");
  endtask

  initial begin
    rst = 1'b1;
    a_load = 0; a_line = '0; a_base = 0; a_bounds = 0; a_pop = 0; a_pv = 0; a_pidx = 0;
    b_load = 0; b_line = '0; b_base = 0; b_bounds = 0; b_pop = 0; b_pv = 0; b_pidx = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_ranges();
    test_empty_range();
    test_back_to_back();
    test_wide();
    test_parser();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
